clock_time_core: RTL and testbench
==================================

Name: clock_time_core

Overview:
Time-of-day engine of the DigitalClock user project. It divides the user clock down to a 1 Hz tick and keeps a binary 24-hour time (hh:mm:ss). It accepts time and alarm loads over a valid/ready handshake. It drives the 18-bit GPIO field mprj_io[25:8] through io_out/io_oeb in the user wrapper.

Parameters:
TICK_DIV, 40, clock cycles per one-second tick; minimum 2. The bench uses a small value; silicon uses the real clock rate.
CW, 6, width of the prescaler counter; must satisfy 2^CW >= TICK_DIV.

Ports:
clock  in  1  user clock
reset  in  1  asynchronous, active-high reset
run_en  in  1  1 = prescaler counts; 0 = time frozen and prescaler held
set_valid  in  1  load request
set_ready  out  1  core can accept a load
set_sel  in  1  0 = load time, 1 = load alarm
set_hour  in  5  hour value 0..23
set_min  in  6  minute value 0..59
set_sec  in  6  second value 0..59
set_ack  out  1  one-cycle pulse: load applied
set_err  out  1  one-cycle pulse: load rejected (field out of range)
alarm_en  in  1  enables alarm comparison
alarm_hit  out  1  one-cycle pulse when time reaches the alarm
day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
io_out  out  18  {tick, hour[4:0], min[5:0], sec[5:0]}
io_oeb  out  18  pad output-enable, active low

Behaviour:
- Reset values:
  - hour/min/sec = 0, prescaler = 0, alarm = 00:00:00.
  - set_ready = 0; set_ack, set_err, alarm_hit, day_wrap = 0.
  - io_out = 0; io_oeb = all 1s.
- First cycle after reset deasserts: io_oeb = 0 and set_ready = 1, both held from then on.
- Prescaler:
  - When run_en = 1: pre counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the cycle in which pre == TICK_DIV-1 and run_en = 1.
  - When run_en = 0: pre holds its value and no tick occurs.
- Time update on tick, registered, visible the cycle after the tick:
  - sec+1. At 59: sec = 0 and min+1.
  - min at 59: min = 0 and hour+1.
  - hour at 23: hour = 0 and day_wrap pulses in the same cycle the time shows 00:00:00.
- io_out[17] is the registered tick, so it is high in the same cycle the new time appears. io_out[16:0] carries the current time.
- Load FSM, states IDLE and RESP:
  - IDLE: set_ready = 1. Accept when set_valid && set_ready.
  - A load is in range when hour <= 23, min <= 59 and sec <= 59; otherwise it is out of range.
  - In range, set_sel = 0: time loaded at the next edge, prescaler cleared to 0, set_ack = 1.
  - In range, set_sel = 1: alarm loaded, set_ack = 1; time and prescaler untouched.
  - Out of range: nothing changes, set_err = 1.
  - After accept -> RESP for one cycle, with set_ready = 0 and the ack/err pulse high. Then -> IDLE.
  - set_valid while set_ready = 0 is ignored. The master must hold valid until it sees ready.
- Simultaneous events:
  - A time load in the same cycle as a tick wins: the loaded value appears and the tick increment is discarded.
  - io_out[17] still reflects that tick.
  - An alarm load with a tick: both take effect.
- alarm_hit pulses one cycle when alarm_en = 1, a tick has just updated the time, and the new time equals the alarm.
  - A time load equal to the alarm does not fire alarm_hit.
  - When set_ack and alarm_hit would coincide, both assert.
- Reset asserted mid-operation (including mid-handshake) immediately returns every register to its reset value; any pending load is dropped.

Decomposition:
- Shared package clock_pkg holds:
  - constants MAX_HOUR = 23, MAX_MIN = 59, MAX_SEC = 59;
  - widths HOUR_W = 5, MIN_W = 6, SEC_W = 6;
  - the io_out bit-field offsets.
- One sub-module, clock_prescaler, implements the TICK_DIV counter and the tick output, with inputs clock, reset and run_en, and clears on the load.
- The rollover counters, load FSM and alarm compare stay in clock_time_core.

Test Plan (TICK_DIV = 4):
1. Reset, then run_en = 1 for 12 cycles -> tick every 4th cycle; sec on io_out[5:0] reads 1, 2, 3; io_oeb = 0 from the first post-reset cycle.
2. Load time 23:59:58, set_sel = 0 -> set_ack for 1 cycle and set_ready low for 1 cycle. After 2 ticks io_out[16:0] = 0 and day_wrap pulses exactly once.
3. Load hour = 24, min = 0, sec = 0 -> set_err pulse; time unchanged; set_ready back high after 1 cycle.
4. Load alarm 00:00:05 with alarm_en = 1, then time 00:00:03 -> alarm_hit pulses on the 2nd tick only. Repeat with alarm_en = 0 -> no pulse.
5. Issue a time load in the same cycle as a tick -> the loaded value appears unincremented, io_out[17] = 1, and the next tick arrives 4 cycles later.
6. Assert reset during RESP with time 12:34:56 -> all outputs are at reset values in that cycle, and no set_ack or set_err pulse is produced after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants, io_out field layout and the load-FSM state type for the
// DigitalClock time-of-day engine.
package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  localparam int IO_W        = 18;
  localparam int IO_SEC_LSB  = 0;
  localparam int IO_MIN_LSB  = 6;
  localparam int IO_HOUR_LSB = 12;
  localparam int IO_TICK_BIT = 17;

  typedef enum logic {S_IDLE, S_RESP} load_state_e;

  function automatic logic time_in_range(input logic [HOUR_W-1:0] h,
                                         input logic [MIN_W-1:0]  m,
                                         input logic [SEC_W-1:0]  s);
    return (h <= MAX_HOUR) && (m <= MAX_MIN) && (s <= MAX_SEC);
  endfunction
endpackage

// File: rtl/clock_prescaler.sv
// Divides the user clock down to a one-cycle tick every TICK_DIV cycles.
module clock_prescaler #(
  parameter int TICK_DIV = 40,
  parameter int CW       = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic run_en,
  input  logic clr,
  output logic tick
);
  localparam logic [CW-1:0] PRE_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre_q, pre_d;

  assign tick = run_en && (pre_q == PRE_MAX);

  // A time load restarts the second so the new time lasts a full period.
  always_comb begin
    pre_d = pre_q;
    if (clr)         pre_d = '0;
    else if (run_en) pre_d = tick ? '0 : pre_q + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end
endmodule

// File: rtl/clock_time_core.sv
// 24-hour hh:mm:ss engine with valid/ready time/alarm loads and the GPIO
// field {tick, hour, min, sec}.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 40,
  parameter int CW       = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_en,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic              set_sel,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic              set_ack,
  output logic              set_err,
  input  logic              alarm_en,
  output logic              alarm_hit,
  output logic              day_wrap,
  output logic [IO_W-1:0]   io_out,
  output logic [IO_W-1:0]   io_oeb
);
  load_state_e       state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d, al_hour_q, al_hour_d;
  logic [MIN_W-1:0]  min_q, min_d, al_min_q, al_min_d;
  logic [SEC_W-1:0]  sec_q, sec_d, al_sec_q, al_sec_d;
  logic              live_q, tick_q, ack_q, ack_d, err_q, err_d;
  logic              hit_q, hit_d, wrap_q, wrap_d;
  logic              tick, accept, in_range, load_time, load_alarm, at_end;

  clock_prescaler #(.TICK_DIV(TICK_DIV), .CW(CW)) u_pre (
    .clock  (clock),
    .reset  (reset),
    .run_en (run_en),
    .clr    (load_time),
    .tick   (tick)
  );

  assign set_ready  = live_q && (state_q == S_IDLE);
  assign accept     = set_valid && set_ready;
  assign in_range   = time_in_range(set_hour, set_min, set_sec);
  assign load_time  = accept && in_range && !set_sel;
  assign load_alarm = accept && in_range && set_sel;
  assign at_end     = (hour_q == MAX_HOUR) && (min_q == MAX_MIN) && (sec_q == MAX_SEC);

  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    al_sec_d  = al_sec_q;
    ack_d     = accept && in_range;
    err_d     = accept && !in_range;

    // A time load overrides a coincident tick; the tick is still shown on io_out.
    if (load_time) begin
      hour_d = set_hour;
      min_d  = set_min;
      sec_d  = set_sec;
    end else if (tick) begin
      if (sec_q == MAX_SEC) begin
        sec_d = '0;
        if (min_q == MAX_MIN) begin
          min_d  = '0;
          hour_d = (hour_q == MAX_HOUR) ? '0 : hour_q + HOUR_W'(1);
        end else begin
          min_d = min_q + MIN_W'(1);
        end
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end

    if (load_alarm) begin
      al_hour_d = set_hour;
      al_min_d  = set_min;
      al_sec_d  = set_sec;
    end

    wrap_d = tick && !load_time && at_end;
    hit_d  = tick && !load_time && alarm_en &&
             ({hour_d, min_d, sec_d} == {al_hour_d, al_min_d, al_sec_d});

    case (state_q)
      S_IDLE:  if (accept) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      al_hour_q <= '0;
      al_min_q  <= '0;
      al_sec_q  <= '0;
      live_q    <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      al_sec_q  <= al_sec_d;
      live_q    <= 1'b1;
      tick_q    <= tick;
      ack_q     <= ack_d;
      err_q     <= err_d;
      hit_q     <= hit_d;
      wrap_q    <= wrap_d;
    end
  end

  assign set_ack   = ack_q;
  assign set_err   = err_q;
  assign alarm_hit = hit_q;
  assign day_wrap  = wrap_q;

  always_comb begin
    io_out = '0;
    io_out[IO_TICK_BIT]                    = tick_q;
    io_out[IO_HOUR_LSB +: HOUR_W]          = hour_q;
    io_out[IO_MIN_LSB +: MIN_W]            = min_q;
    io_out[IO_SEC_LSB +: SEC_W]            = sec_q;
  end

  assign io_oeb = {IO_W{~live_q}};
endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core: a seconds-of-day model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_clock_time_core;
  localparam int TD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run_en = 1'b0, set_valid = 1'b0, set_sel = 1'b0, alarm_en = 1'b0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_min = '0, set_sec = '0;
  logic        set_ready, set_ack, set_err, alarm_hit, day_wrap;
  logic [17:0] io_out, io_oeb;

  int checks = 0;
  int failures = 0;

  clock_time_core #(.TICK_DIV(TD), .CW(3)) dut (
    .clock(clock), .reset(reset), .run_en(run_en),
    .set_valid(set_valid), .set_ready(set_ready), .set_sel(set_sel),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_ack(set_ack), .set_err(set_err), .alarm_en(alarm_en),
    .alarm_hit(alarm_hit), .day_wrap(day_wrap), .io_out(io_out), .io_oeb(io_oeb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: time held as seconds since midnight, prescaler as a modulo count.
  int m_t = 0, m_pre = 0, m_alarm = 0;
  bit m_live = 0, m_resp = 0, m_tick = 0, m_ack = 0, m_err = 0, m_hit = 0, m_wrap = 0;
  bit e_rdy, e_tk, e_acc, e_ok, e_lt, e_la, e_hit, e_wrap;
  int e_nt, e_na, e_pre;

  always_comb begin
    e_rdy  = m_live && !m_resp;
    e_tk   = run_en && (m_pre == TD - 1);
    e_acc  = set_valid && e_rdy;
    e_ok   = (int'(set_hour) < 24) && (int'(set_min) < 60) && (int'(set_sec) < 60);
    e_lt   = e_acc && e_ok && !set_sel;
    e_la   = e_acc && e_ok && set_sel;
    e_nt   = m_t;
    e_wrap = 0;
    if (e_lt) e_nt = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
    else if (e_tk) begin
      e_nt   = (m_t + 1) % 86400;
      e_wrap = (e_nt == 0);
    end
    e_na  = e_la ? int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec) : m_alarm;
    e_hit = e_tk && !e_lt && alarm_en && (e_nt == e_na);
    e_pre = e_lt ? 0 : (run_en ? (m_pre + 1) % TD : m_pre);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_t <= 0; m_pre <= 0; m_alarm <= 0; m_live <= 0; m_resp <= 0;
      m_tick <= 0; m_ack <= 0; m_err <= 0; m_hit <= 0; m_wrap <= 0;
    end else begin
      m_t <= e_nt; m_pre <= e_pre; m_alarm <= e_na; m_live <= 1;
      m_resp <= e_acc; m_tick <= e_tk; m_ack <= e_acc && e_ok;
      m_err <= e_acc && !e_ok; m_hit <= e_hit; m_wrap <= e_wrap;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("cyc_io_out", {14'd0, io_out},
          {14'd0, m_tick, 5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60)});
      chk("cyc_io_oeb", {14'd0, io_oeb}, m_live ? 32'h0 : 32'h3ffff);
      chk("cyc_ready", {31'd0, set_ready}, {31'd0, m_live && !m_resp});
      chk("cyc_pulses", {28'd0, set_ack, set_err, alarm_hit, day_wrap},
          {28'd0, m_ack, m_err, m_hit, m_wrap});
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_load(input logic sel, input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic ok, input string tag,
                         output logic [17:0] io_at_acc);
    int n = 0;
    set_sel = sel; set_hour = h; set_min = m; set_sec = s; set_valid = 1'b1;
    while (!set_ready && n < 20) begin step(); n++; end
    chk({tag, "_ready_wait"}, {31'd0, set_ready}, 32'd1);
    step();
    set_valid = 1'b0;
    io_at_acc = io_out;
    chk({tag, "_ready_low"}, {31'd0, set_ready}, 32'd0);
    chk({tag, "_ack"}, {31'd0, set_ack}, {31'd0, ok});
    chk({tag, "_err"}, {31'd0, set_err}, {31'd0, ~ok});
    step();
    chk({tag, "_ready_back"}, {31'd0, set_ready}, 32'd1);
    chk({tag, "_pulse_end"}, {30'd0, set_ack, set_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] io_acc;
    int tk, wraps, hits, hit_at, n;
    int secs[$];

    // Reset state
    step(); step();
    chk("rst_io_out", {14'd0, io_out}, 32'd0);
    chk("rst_io_oeb", {14'd0, io_oeb}, 32'h3ffff);
    chk("rst_ready", {31'd0, set_ready}, 32'd0);
    chk("rst_pulses", {28'd0, set_ack, set_err, alarm_hit, day_wrap}, 32'd0);
    reset = 1'b0;
    run_en = 1'b1;

    // 1: free run, tick every 4th cycle
    step();
    chk("t1_oeb", {14'd0, io_oeb}, 32'd0);
    chk("t1_ready", {31'd0, set_ready}, 32'd1);
    if (io_out[17]) secs.push_back(int'(io_out[5:0]));
    for (int i = 1; i < 12; i++) begin
      step();
      if (io_out[17]) secs.push_back(int'(io_out[5:0]));
    end
    chk("t1_ticks", secs.size(), 32'd3);
    for (int i = 0; i < secs.size() && i < 3; i++) chk("t1_sec", secs[i], i + 1);

    // 2: 23:59:58 rolls to midnight after two ticks
    do_load(1'b0, 5'd23, 6'd59, 6'd58, 1'b1, "t2", io_acc);
    tk = 0; wraps = 0; n = 0;
    while (tk < 2 && n < 40) begin
      step(); n++;
      if (io_out[17]) tk++;
      if (day_wrap) wraps++;
    end
    run_en = 1'b0;
    chk("t2_ticks", tk, 32'd2);
    chk("t2_midnight", {15'd0, io_out[16:0]}, 32'd0);
    step();
    if (day_wrap) wraps++;
    chk("t2_wraps", wraps, 32'd1);

    // 3: out-of-range loads
    do_load(1'b0, 5'd24, 6'd0, 6'd0, 1'b0, "t3h", io_acc);
    chk("t3_time_kept", {15'd0, io_out[16:0]}, 32'd0);
    do_load(1'b1, 5'd0, 6'd60, 6'd0, 1'b0, "t3m", io_acc);

    // 4: alarm at 00:00:05 from 00:00:03
    alarm_en = 1'b1;
    do_load(1'b1, 5'd0, 6'd0, 6'd5, 1'b1, "t4a", io_acc);
    run_en = 1'b1;
    do_load(1'b0, 5'd0, 6'd0, 6'd3, 1'b1, "t4t", io_acc);
    tk = 0; hits = 0; hit_at = 0; n = 0;
    while (tk < 2 && n < 40) begin
      step(); n++;
      if (io_out[17]) tk++;
      if (alarm_hit) begin hits++; hit_at = tk; end
    end
    chk("t4_hits", hits, 32'd1);
    chk("t4_hit_tick", hit_at, 32'd2);
    chk("t4_sec", {26'd0, io_out[5:0]}, 32'd5);
    alarm_en = 1'b0;
    do_load(1'b0, 5'd0, 6'd0, 6'd3, 1'b1, "t4u", io_acc);
    tk = 0; hits = 0; n = 0;
    while (tk < 2 && n < 40) begin
      step(); n++;
      if (io_out[17]) tk++;
      if (alarm_hit) hits++;
    end
    chk("t4_nohit", hits, 32'd0);

    // 5: time load coinciding with a tick
    do_load(1'b0, 5'd1, 6'd2, 6'd3, 1'b1, "t5a", io_acc);
    step(); step();
    chk("t5_pre_tick", {31'd0, io_out[17]}, 32'd0);
    do_load(1'b0, 5'd10, 6'd20, 6'd30, 1'b1, "t5", io_acc);
    chk("t5_load_tick", {14'd0, io_acc}, {14'd0, 1'b1, 5'd10, 6'd20, 6'd30});
    step();
    chk("t5_no_tick6", {31'd0, io_out[17]}, 32'd0);
    step();
    chk("t5_no_tick7", {31'd0, io_out[17]}, 32'd0);
    step();
    chk("t5_next_tick", {14'd0, io_out}, {14'd0, 1'b1, 5'd10, 6'd20, 6'd31});

    // 6: reset during RESP
    run_en = 1'b0;
    set_sel = 1'b0; set_hour = 5'd12; set_min = 6'd34; set_sec = 6'd56; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("t6_in_resp", {31'd0, set_ack}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_io_out", {14'd0, io_out}, 32'd0);
    chk("t6_rst_oeb", {14'd0, io_oeb}, 32'h3ffff);
    chk("t6_rst_ready", {31'd0, set_ready}, 32'd0);
    chk("t6_rst_pulses", {28'd0, set_ack, set_err, alarm_hit, day_wrap}, 32'd0);
    step();
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (set_ack || set_err) hits++;
    end
    chk("t6_no_resp", hits, 32'd0);
    chk("t6_ready", {31'd0, set_ready}, 32'd1);
    chk("t6_time_clear", {14'd0, io_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
